// File: rtl/mailbox_writer.sv
// Streams producer words into a small mailbox memory and rings a doorbell (irq) per message.
// Optional macro MAILBOX_WRITER_ACK_TIMEOUT_EN adds an ack watchdog and the ack_timeout pulse.
module mailbox_writer #(
  parameter int MESSAGE_DEPTH = 1,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        mb_wr,
  output logic [2:0]  mb_wr_sel,
  output logic [31:0] mb_wdata,
  input  logic        mb_wr_ready,
  output logic        irq,
  input  logic        irq_ack,
  output logic [3:0]  msg_len,
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
  output logic        ack_timeout,
`endif
  output logic        overflow
);

  if (MESSAGE_DEPTH < 1 || MESSAGE_DEPTH > 8 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("mailbox_writer: MESSAGE_DEPTH must be 1..8 and ACK_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DRAIN,
    ST_NOTIFY
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic        r_irq;
  logic [3:0]  r_msg_len;
  logic        r_overflow;

  logic        w_s_ready;
  logic        w_in_write;
  logic        w_beat;
  logic        w_last_slot;

`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [CNT_W-1:0] r_ack_cnt;
  logic             r_ack_timeout;
  assign ack_timeout = r_ack_timeout;
`endif

  assign w_in_write  = (r_state == ST_IDLE) || (r_state == ST_WRITE);
  assign w_last_slot = (r_idx == 3'(MESSAGE_DEPTH - 1));

  // NOTE: give every always_comb output a default before any branch so no latch is inferred.
  always_comb begin
    w_s_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE, ST_WRITE: w_s_ready = mb_wr_ready;
        ST_DRAIN:          w_s_ready = 1'b1;
        default:           w_s_ready = 1'b0;
      endcase
    end
  end

  // Writes go out in the same cycle as the accepted beat; s_ready is already low in reset.
  assign w_beat    = s_valid & w_s_ready;
  assign s_ready   = w_s_ready;
  assign mb_wr     = w_beat & w_in_write;
  assign mb_wr_sel = r_idx;
  assign mb_wdata  = s_data;
  assign irq       = r_irq;
  assign msg_len   = r_msg_len;
  assign overflow  = r_overflow;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_irq      <= 1'b0;
      r_msg_len  <= 4'd0;
      r_overflow <= 1'b0;
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
      r_ack_cnt     <= '0;
      r_ack_timeout <= 1'b0;
`endif
    end else begin
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
      r_ack_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_beat) begin
            if (s_last) begin
              r_msg_len <= {1'b0, r_idx} + 4'd1;
              r_irq     <= 1'b1;
              r_state   <= ST_NOTIFY;
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
              r_ack_cnt <= '0;
`endif
            end else if (w_last_slot) begin
              // Mailbox is full: keep what fits and swallow the rest of the message.
              r_msg_len  <= 4'(MESSAGE_DEPTH);
              r_overflow <= 1'b1;
              r_state    <= ST_DRAIN;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_beat && s_last) begin
            r_irq   <= 1'b1;
            r_state <= ST_NOTIFY;
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
            r_ack_cnt <= '0;
`endif
          end
        end
        ST_NOTIFY: begin
          if (irq_ack) begin
            r_irq   <= 1'b0;
            r_idx   <= 3'd0;
            r_state <= ST_IDLE;
          end
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
          else if (r_ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            r_irq         <= 1'b0;
            r_idx         <= 3'd0;
            r_state       <= ST_IDLE;
            r_ack_timeout <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mailbox_writer.sv
// Directed bench for mailbox_writer: depth-4 and depth-2 instances driven independently.
module tb_mailbox_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_valid, a_last, a_mbrdy, a_ack;
  logic [31:0] a_data;
  logic        a_ready, a_wr, a_irq, a_ovf;
  logic [2:0]  a_sel;
  logic [31:0] a_wdata;
  logic [3:0]  a_len;

  logic        b_valid, b_last, b_mbrdy, b_ack;
  logic [31:0] b_data;
  logic        b_ready, b_wr, b_irq, b_ovf;
  logic [2:0]  b_sel;
  logic [31:0] b_wdata;
  logic [3:0]  b_len;

`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
  logic a_to, b_to;
`endif

  mailbox_writer #(.MESSAGE_DEPTH(4), .ACK_TIMEOUT(8)) u_d4 (
    .clk(clk), .reset(reset),
    .s_valid(a_valid), .s_data(a_data), .s_last(a_last), .s_ready(a_ready),
    .mb_wr(a_wr), .mb_wr_sel(a_sel), .mb_wdata(a_wdata), .mb_wr_ready(a_mbrdy),
    .irq(a_irq), .irq_ack(a_ack), .msg_len(a_len),
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
    .ack_timeout(a_to),
`endif
    .overflow(a_ovf)
  );

  mailbox_writer #(.MESSAGE_DEPTH(2), .ACK_TIMEOUT(8)) u_d2 (
    .clk(clk), .reset(reset),
    .s_valid(b_valid), .s_data(b_data), .s_last(b_last), .s_ready(b_ready),
    .mb_wr(b_wr), .mb_wr_sel(b_sel), .mb_wdata(b_wdata), .mb_wr_ready(b_mbrdy),
    .irq(b_irq), .irq_ack(b_ack), .msg_len(b_len),
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
    .ack_timeout(b_to),
`endif
    .overflow(b_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [31:0] d, input logic l, input logic [2:0] sel);
    a_valid = 1'b1; a_data = d; a_last = l;
    #1;
    check("a_beat_wr", a_wr, 1);
    check("a_beat_sel", a_sel, sel);
    check("a_beat_wdata", a_wdata, d);
    step();
  endtask

  task automatic b_beat(input logic [31:0] d, input logic l, input logic [2:0] sel);
    b_valid = 1'b1; b_data = d; b_last = l;
    #1;
    check("b_beat_wr", b_wr, 1);
    check("b_beat_sel", b_sel, sel);
    step();
  endtask

  task automatic a_do_ack();
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    #1;
    check("a_irq_clr", a_irq, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_valid = 1'b1; a_data = 32'h0; a_last = 1'b0; a_mbrdy = 1'b1; a_ack = 1'b0;
    b_valid = 1'b1; b_data = 32'h0; b_last = 1'b0; b_mbrdy = 1'b1; b_ack = 1'b0;
    step();
    step();
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_a_wr", a_wr, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_b_wr", b_wr, 0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("rst_irq", a_irq, 0);
    check("rst_len", a_len, 0);
    check("rst_ovf", a_ovf, 0);
    check("idle_ready", a_ready, 1);
    step();

    // Three-word message, last on slot 2.
    for (int i = 0; i < 3; i++) a_beat(32'hA0 + 32'(i), (i == 2), 3'(i));
    a_valid = 1'b0;
    #1;
    check("m1_irq", a_irq, 1);
    check("m1_len", a_len, 3);
    check("m1_ovf", a_ovf, 0);
    check("m1_notify_ready", a_ready, 0);

    // Producer pushes during NOTIFY: must be held off until acked.
    a_valid = 1'b1; a_data = 32'hB0; a_last = 1'b0;
    #1;
    check("notify_ready", a_ready, 0);
    check("notify_wr", a_wr, 0);
    step();
    #1;
    check("notify_irq_hold", a_irq, 1);
    a_do_ack();
    a_beat(32'hB0, 1'b0, 3'd0);
    a_beat(32'hB1, 1'b0, 3'd1);

    // Mailbox back-pressure for three cycles mid-message.
    a_valid = 1'b1; a_data = 32'hB2; a_last = 1'b1; a_mbrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", a_ready, 0);
      check("stall_wr", a_wr, 0);
      check("stall_sel", a_sel, 2);
      step();
    end
    a_mbrdy = 1'b1;
    a_beat(32'hB2, 1'b1, 3'd2);
    a_valid = 1'b0;
    #1;
    check("m2_irq", a_irq, 1);
    check("m2_len", a_len, 3);
    a_do_ack();

    // Exactly fills the mailbox: no overflow.
    for (int i = 0; i < 4; i++) a_beat(32'hC0 + 32'(i), (i == 3), 3'(i));
    a_valid = 1'b0;
    #1;
    check("full_len", a_len, 4);
    check("full_ovf", a_ovf, 0);
    check("full_irq", a_irq, 1);
    a_do_ack();

    // Reset while in WRITE with idx=2.
    a_beat(32'hD0, 1'b0, 3'd0);
    a_beat(32'hD1, 1'b0, 3'd1);
    a_valid = 1'b1; a_data = 32'hD2; a_last = 1'b0; reset = 1'b1;
    #1;
    check("midrst_sel_before", a_sel, 2);
    check("midrst_ready", a_ready, 0);
    check("midrst_wr", a_wr, 0);
    step();
    reset = 1'b0; a_valid = 1'b0;
    #1;
    check("midrst_irq", a_irq, 0);
    check("midrst_sel", a_sel, 0);
    check("midrst_len", a_len, 0);
    a_beat(32'hE0, 1'b1, 3'd0);
    a_valid = 1'b0;
    #1;
    check("post_rst_irq", a_irq, 1);
    check("post_rst_len", a_len, 1);
    a_do_ack();

    // Depth-2 instance: four words, last two dropped.
    b_beat(32'hF0, 1'b0, 3'd0);
    b_beat(32'hF1, 1'b0, 3'd1);
    b_valid = 1'b1; b_data = 32'hF2; b_last = 1'b0;
    #1;
    check("drain_wr3", b_wr, 0);
    check("drain_ready", b_ready, 1);
    check("drain_ovf", b_ovf, 1);
    check("drain_irq", b_irq, 0);
    step();
    b_data = 32'hF3; b_last = 1'b1;
    #1;
    check("drain_wr4", b_wr, 0);
    step();
    b_valid = 1'b0;
    #1;
    check("ovf_irq", b_irq, 1);
    check("ovf_len", b_len, 2);
    check("ovf_flag", b_ovf, 1);
    b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    #1;
    check("ovf_irq_clr", b_irq, 0);
    check("ovf_sticky", b_ovf, 1);

    // No acknowledge from the consumer.
    a_beat(32'h60, 1'b1, 3'd0);
    a_valid = 1'b0;
`ifdef MAILBOX_WRITER_ACK_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      check("to_irq_hold", a_irq, 1);
      check("to_pulse_low", a_to, 0);
      step();
    end
    #1;
    check("to_irq_drop", a_irq, 0);
    check("to_pulse", a_to, 1);
    step();
    #1;
    check("to_pulse_end", a_to, 0);
    a_beat(32'h61, 1'b1, 3'd0);
    a_valid = 1'b0;
    a_do_ack();
`else
    repeat (20) step();
    #1;
    check("noto_irq_hold", a_irq, 1);
    a_do_ack();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
